// File: rtl/gate_sensor_conditioner.sv
// Entrance/exit beam conditioner: synchronise, debounce and edge-detect both
// beams, then admit or refuse each arrival against the lot occupancy count.
module gate_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CAPACITY        = 100,
    parameter int CNT_W           = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw_entrance,
    input  logic             raw_exit,
    input  logic             clear_count,
    output logic             sensor_entrance,
    output logic             sensor_exit,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             reject_pulse,
    output logic             underflow_pulse
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);

    // Channel 0 is the entrance beam, channel 1 the exit beam.
    logic [1:0]      raw;
    logic [1:0]      sync_1;
    logic [1:0]      sync_2;
    logic [1:0]      deb;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      rise;
    logic            ent_ok;
    logic            ex_ok;

    assign raw = {raw_exit, raw_entrance};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
            deb    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A rise is the cycle in which the debounced level is about to flip 0->1.
    always_comb begin
        rise = '0;
        for (int i = 0; i < 2; i++) begin
            rise[i] = sync_2[i] && !deb[i] && (db_cnt[i] == DB_LAST);
        end
    end

    // A simultaneous accepted exit frees the slot, so a full lot still admits.
    assign ex_ok  = rise[1] && (occupancy != '0);
    assign ent_ok = rise[0] && ((occupancy < CAP) || ex_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sensor_entrance <= 1'b0;
            sensor_exit     <= 1'b0;
            reject_pulse    <= 1'b0;
            underflow_pulse <= 1'b0;
            occupancy       <= '0;
        end else begin
            sensor_entrance <= ent_ok;
            sensor_exit     <= ex_ok;
            reject_pulse    <= rise[0] && !ent_ok;
            underflow_pulse <= rise[1] && !ex_ok;
            if (clear_count) begin
                occupancy <= '0;
            end else if (ent_ok && !ex_ok) begin
                occupancy <= occupancy + CNT_W'(1);
            end else if (ex_ok && !ent_ok) begin
                occupancy <= occupancy - CNT_W'(1);
            end
        end
    end

    assign lot_full  = (occupancy == CAP);
    assign lot_empty = (occupancy == '0);

endmodule

// File: tb/tb_gate_sensor_conditioner.sv
// Directed bench for gate_sensor_conditioner with DEBOUNCE_CYCLES=16, CAPACITY=4.
module tb_gate_sensor_conditioner;

    localparam int DB    = 16;
    localparam int CAP   = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             raw_entrance = 1'b0;
    logic             raw_exit = 1'b0;
    logic             clear_count = 1'b0;
    logic             sensor_entrance;
    logic             sensor_exit;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full;
    logic             lot_empty;
    logic             reject_pulse;
    logic             underflow_pulse;

    int total = 0;
    int bad   = 0;
    int n_ent = 0;
    int n_ex  = 0;
    int n_rej = 0;
    int n_und = 0;

    gate_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CAPACITY(CAP),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .raw_entrance(raw_entrance),
        .raw_exit(raw_exit),
        .clear_count(clear_count),
        .sensor_entrance(sensor_entrance),
        .sensor_exit(sensor_exit),
        .occupancy(occupancy),
        .lot_full(lot_full),
        .lot_empty(lot_empty),
        .reject_pulse(reject_pulse),
        .underflow_pulse(underflow_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sensor_entrance) n_ent++;
        if (sensor_exit) n_ex++;
        if (reject_pulse) n_rej++;
        if (underflow_pulse) n_und++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic arrive(input logic e, input logic x);
        raw_entrance = e;
        raw_exit     = x;
        tick(25);
        raw_entrance = 1'b0;
        raw_exit     = 1'b0;
        tick(25);
    endtask

    task automatic check_occ(input string name, input int exp_occ, input logic exp_full, input logic exp_empty);
        total++;
        if (occupancy !== CNT_W'(exp_occ)) begin
            bad++;
            $display("FAIL %s occupancy got=%0d want=%0d", name, occupancy, exp_occ);
        end
        total++;
        if ({lot_full, lot_empty} !== {exp_full, exp_empty}) begin
            bad++;
            $display("FAIL %s flags full/empty got=%b%b want=%b%b", name, lot_full, lot_empty, exp_full, exp_empty);
        end
    endtask

    task automatic check_counts(input string name, input int d_ent, input int d_ex, input int d_rej, input int d_und,
                                input int e_ent, input int e_ex, input int e_rej, input int e_und);
        total++;
        if ({d_ent, d_ex, d_rej, d_und} !== {e_ent, e_ex, e_rej, e_und}) begin
            bad++;
            $display("FAIL %s pulses ent/ex/rej/und got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                     name, d_ent, d_ex, d_rej, d_und, e_ent, e_ex, e_rej, e_und);
        end
    endtask

    task automatic test_reset();
        tick(3);
        check_occ("reset", 0, 1'b0, 1'b1);
        total++;
        if ({sensor_entrance, sensor_exit, reject_pulse, underflow_pulse} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_pulses got=%b want=0000",
                     {sensor_entrance, sensor_exit, reject_pulse, underflow_pulse});
        end
        reset_n = 1'b1;
        tick(100);
        check_counts("idle", n_ent, n_ex, n_rej, n_und, 0, 0, 0, 0);
        check_occ("idle", 0, 1'b0, 1'b1);
    endtask

    task automatic test_latency();
        int seen;
        int first;
        seen  = 0;
        first = -1;
        raw_entrance = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sensor_entrance) begin
                seen++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (seen !== 1 || first !== DB + 1) begin
            bad++;
            $display("FAIL latency pulses=%0d at_edge=%0d want pulses=1 at_edge=%0d", seen, first, DB + 1);
        end
        check_occ("latency", 1, 1'b0, 1'b0);
        raw_entrance = 1'b0;
        tick(25);
    endtask

    task automatic test_glitch();
        int e0;
        e0 = n_ent;
        raw_entrance = 1'b1;
        tick(DB - 1);
        raw_entrance = 1'b0;
        tick(25);
        check_counts("glitch", n_ent - e0, 0, 0, 0, 0, 0, 0, 0);
        check_occ("glitch", 1, 1'b0, 1'b0);
    endtask

    task automatic test_bounce();
        int e0;
        e0 = n_ent;
        for (int i = 0; i < 5; i++) begin
            raw_entrance = 1'b1;
            tick(3);
            raw_entrance = 1'b0;
            tick(3);
        end
        raw_entrance = 1'b1;
        tick(40);
        raw_entrance = 1'b0;
        tick(25);
        check_counts("bounce", n_ent - e0, 0, 0, 0, 1, 0, 0, 0);
        check_occ("bounce", 2, 1'b0, 1'b0);
    endtask

    task automatic test_full();
        int e0, x0, r0, u0;
        arrive(1'b1, 1'b0);
        arrive(1'b1, 1'b0);
        check_occ("fill", 4, 1'b1, 1'b0);
        e0 = n_ent; x0 = n_ex; r0 = n_rej; u0 = n_und;
        arrive(1'b1, 1'b0);
        check_counts("reject", n_ent - e0, n_ex - x0, n_rej - r0, n_und - u0, 0, 0, 1, 0);
        check_occ("reject", 4, 1'b1, 1'b0);
    endtask

    task automatic test_simul_full();
        int e0, x0, r0, u0;
        e0 = n_ent; x0 = n_ex; r0 = n_rej; u0 = n_und;
        arrive(1'b1, 1'b1);
        check_counts("simul_full", n_ent - e0, n_ex - x0, n_rej - r0, n_und - u0, 1, 1, 0, 0);
        check_occ("simul_full", 4, 1'b1, 1'b0);
        e0 = n_ent; x0 = n_ex;
        arrive(1'b0, 1'b1);
        check_counts("exit", n_ent - e0, n_ex - x0, 0, 0, 0, 1, 0, 0);
        check_occ("exit", 3, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        raw_entrance = 1'b1;
        for (int i = 0; i <= DB + 1; i++) begin
            @(posedge clk);
            @(negedge clk);
            clear_count = (i == DB);
        end
        clear_count = 1'b0;
        total++;
        if (sensor_entrance !== 1'b1) begin
            bad++;
            $display("FAIL clear_pulse sensor_entrance got=%b want=1", sensor_entrance);
        end
        check_occ("clear", 0, 1'b0, 1'b1);
        raw_entrance = 1'b0;
        tick(25);
        check_occ("clear_hold", 0, 1'b0, 1'b1);
    endtask

    task automatic test_empty();
        int e0, x0, r0, u0;
        e0 = n_ent; x0 = n_ex; r0 = n_rej; u0 = n_und;
        arrive(1'b0, 1'b1);
        check_counts("underflow", n_ent - e0, n_ex - x0, n_rej - r0, n_und - u0, 0, 0, 0, 1);
        check_occ("underflow", 0, 1'b0, 1'b1);
        e0 = n_ent; x0 = n_ex; r0 = n_rej; u0 = n_und;
        arrive(1'b1, 1'b1);
        check_counts("simul_empty", n_ent - e0, n_ex - x0, n_rej - r0, n_und - u0, 1, 0, 0, 1);
        check_occ("simul_empty", 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int e0;
        raw_entrance = 1'b1;
        tick(8);
        #2 reset_n = 1'b0;
        #1;
        check_occ("reset_mid", 0, 1'b0, 1'b1);
        tick(3);
        reset_n = 1'b1;
        e0 = n_ent;
        tick(40);
        check_counts("reset_held", n_ent - e0, 0, 0, 0, 1, 0, 0, 0);
        check_occ("reset_held", 1, 1'b0, 1'b0);
        raw_entrance = 1'b0;
        tick(25);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_bounce();
        test_full();
        test_simul_full();
        test_clear();
        test_empty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
